// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM port-A arbiter and its fill sequencer.
package vram_pkg;

   localparam logic [5:0] PAGE_CHARMAP = 6'h08;
   localparam logic [5:0] PAGE_CHARDAT = 6'h09;
   localparam logic [7:0] MISS_RDATA   = 8'hFF;

   typedef enum logic [1:0] {REG_CHARMAP, REG_CHARDAT, REG_NONE} region_e;
   typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_e;

   function automatic region_e decode_region(input logic [5:0] page,
                                             input logic [5:0] map_page,
                                             input logic [5:0] dat_page);
      if (page == map_page) return REG_CHARMAP;
      if (page == dat_page) return REG_CHARDAT;
      return REG_NONE;
   endfunction

endpackage

// File: rtl/vram_fill_seq.sv
// Fill engine: latches a fill command and requests one port-A write slot per byte,
// advancing only on the slots the arbiter grants.
module vram_fill_seq
   import vram_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fill_start,
   input  logic        fill_sel,
   input  logic [9:0]  fill_base,
   input  logic [10:0] fill_len,
   input  logic [7:0]  fill_value,
   input  logic        gnt,
   output logic        req,
   output logic        busy,
   output logic        done,
   output logic [9:0]  addr,
   output logic [7:0]  value,
   output logic        sel
);

   fill_state_e state_q, state_d;
   logic [9:0]  base_q, base_d;
   logic [10:0] len_q, len_d;
   logic [10:0] idx_q, idx_d;
   logic [7:0]  val_q, val_d;
   logic        sel_q, sel_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      val_d   = val_q;
      sel_d   = sel_q;
      case (state_q)
         FILL_IDLE: begin
            if (fill_start) begin
               base_d  = fill_base;
               len_d   = fill_len;
               val_d   = fill_value;
               sel_d   = fill_sel;
               idx_d   = '0;
               state_d = (fill_len == 11'd0) ? FILL_DONE : FILL_RUN;
            end
         end
         FILL_RUN: begin
            if (gnt) begin
               idx_d = idx_q + 11'd1;
               if (idx_q == len_q - 11'd1) state_d = FILL_DONE;
            end
         end
         FILL_DONE: state_d = FILL_IDLE;
         default:   state_d = FILL_IDLE;
      endcase
   end

   assign req   = (state_q == FILL_RUN);
   assign busy  = (state_q != FILL_IDLE);
   assign done  = (state_q == FILL_DONE);
   // 10-bit add wraps the fill address around the top of the RAM.
   assign addr  = base_q + idx_q[9:0];
   assign value = val_q;
   assign sel   = sel_q;

endmodule

// File: rtl/vram_arbiter.sv
// Port-A controller for charmap/chardata: CPU decode, read pipeline and, when
// VRAM_FILL_EN is defined, the fill engine with bounded-starvation arbitration.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter logic [5:0] CHARMAP_PAGE = PAGE_CHARMAP,
   parameter logic [5:0] CHARDAT_PAGE = PAGE_CHARDAT,
   parameter int         STARVE_MAX   = 8
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_rvalid,
   output logic [7:0]  cpu_rdata,
   input  logic        fill_start,
   input  logic        fill_sel,
   input  logic [9:0]  fill_base,
   input  logic [10:0] fill_len,
   input  logic [7:0]  fill_value,
   output logic        fill_busy,
   output logic        fill_done,
   output logic [9:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        charmap_we,
   output logic        chardat_we,
   input  logic [7:0]  charmap_q,
   input  logic [7:0]  chardat_q
);

   region_e     cpu_reg;
   logic        cpu_gnt, fill_gnt, fill_sel_w;
   logic [9:0]  fill_addr;
   logic [7:0]  fill_val;

   assign cpu_reg = decode_region(cpu_addr[15:10], CHARMAP_PAGE, CHARDAT_PAGE);

`ifdef VRAM_FILL_EN
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
   logic       fill_req;
   logic [7:0] starve_q, starve_d;

   // CPU wins by default; the fill takes the slot when the CPU is idle or starved it.
   assign cpu_gnt  = cpu_req && !(fill_req && (starve_q == STARVE_LIM));
   assign fill_gnt = fill_req && !cpu_gnt;

   always_comb begin
      starve_d = starve_q;
      if (fill_gnt || !fill_busy) starve_d = '0;
      else if (cpu_gnt)           starve_d = starve_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end

   vram_fill_seq u_fill (
      .clk        (clk),
      .rst_n      (rst_n),
      .fill_start (fill_start),
      .fill_sel   (fill_sel),
      .fill_base  (fill_base),
      .fill_len   (fill_len),
      .fill_value (fill_value),
      .gnt        (fill_gnt),
      .req        (fill_req),
      .busy       (fill_busy),
      .done       (fill_done),
      .addr       (fill_addr),
      .value      (fill_val),
      .sel        (fill_sel_w)
   );
`else
   logic unused_fill;
   assign unused_fill = ^{fill_start, fill_sel, fill_base, fill_len, fill_value};
   assign cpu_gnt    = cpu_req;
   assign fill_gnt   = 1'b0;
   assign fill_busy  = 1'b0;
   assign fill_done  = 1'b0;
   assign fill_addr  = '0;
   assign fill_val   = '0;
   assign fill_sel_w = 1'b0;
`endif

   logic       ack_q, ack_d;
   logic [9:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       map_we_q, map_we_d, dat_we_q, dat_we_d;
   logic       vld_p0_q, vld_p0_d, vld_p1_q, rvalid_q;
   region_e    reg_p0_q, reg_p0_d, reg_p1_q;
   logic [7:0] rdata_q;

   always_comb begin
      ack_d    = cpu_gnt;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      map_we_d = 1'b0;
      dat_we_d = 1'b0;
      vld_p0_d = 1'b0;
      reg_p0_d = reg_p0_q;
      if (cpu_gnt) begin
         addr_d   = cpu_addr[9:0];
         wdata_d  = cpu_wdata;
         map_we_d = cpu_we && (cpu_reg == REG_CHARMAP);
         dat_we_d = cpu_we && (cpu_reg == REG_CHARDAT);
         vld_p0_d = !cpu_we;
         reg_p0_d = cpu_reg;
      end else if (fill_gnt) begin
         addr_d   = fill_addr;
         wdata_d  = fill_val;
         map_we_d = !fill_sel_w;
         dat_we_d = fill_sel_w;
      end
   end

   // Read pipeline: p0 = address on port A, p1 = RAM output valid, then registered data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         map_we_q <= 1'b0;
         dat_we_q <= 1'b0;
         vld_p0_q <= 1'b0;
         reg_p0_q <= REG_CHARMAP;
         vld_p1_q <= 1'b0;
         reg_p1_q <= REG_CHARMAP;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         ack_q    <= ack_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         map_we_q <= map_we_d;
         dat_we_q <= dat_we_d;
         vld_p0_q <= vld_p0_d;
         reg_p0_q <= reg_p0_d;
         vld_p1_q <= vld_p0_q;
         reg_p1_q <= reg_p0_q;
         rvalid_q <= vld_p1_q;
         if (vld_p1_q) begin
            case (reg_p1_q)
               REG_CHARMAP: rdata_q <= charmap_q;
               REG_CHARDAT: rdata_q <= chardat_q;
               default:     rdata_q <= MISS_RDATA;
            endcase
         end
      end
   end

   assign cpu_ack    = ack_q;
   assign cpu_rvalid = rvalid_q;
   assign cpu_rdata  = rdata_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign charmap_we = map_we_q;
   assign chardat_we = dat_we_q;

endmodule
